stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Parametrised stopwatch engine: an internal prescaler produces a tick at `TICK_HZ` from the board clock and advances a chain of `NUM_DIGITS` cascaded digit counters, each with its own base. Adds start/stop, clear and lap-freeze control, which the fixed free-running seconds counter lacks. Sits between the reset conditioner and button debouncers on the input side and the digit display driver on the output side. Its `digits` bus feeds the display directly.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000, board clock frequency.
- `TICK_HZ`, 100, rate of least-significant digit increments. `CLK_FREQ_HZ` must be an exact multiple of `TICK_HZ`; elaboration error otherwise.
- `NUM_DIGITS`, 4, number of cascaded digits (1..8).
- `DIGIT_BASES`, {4'd6,4'd10,4'd10,4'd10}, packed 4 bits per digit with digit 0 in the LSBs. Each base must be 2..10; elaboration error otherwise.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start_stop`  in  1  one-cycle pulse that toggles running/paused.
- `clear`  in  1  one-cycle pulse that zeroes the count and returns to IDLE.
- `lap`  in  1  one-cycle pulse that toggles the display freeze.
- `digits`  out  4*NUM_DIGITS  displayed value, one binary digit per nibble, digit 0 in the LSBs.
- `running`  out  1  high in RUNNING.
- `lap_active`  out  1  high while the display is frozen.
- `wrap`  out  1  one-cycle pulse when the count rolls over from all-max to zero.

## Operation
- States:
  - IDLE: count zero, prescaler zero.
  - RUNNING: prescaler counts; tick advances digits.
  - PAUSED: prescaler and digits hold; any partial tick is preserved.
- Transitions:
  - IDLE to RUNNING on `start_stop`.
  - RUNNING to PAUSED on `start_stop`.
  - PAUSED to RUNNING on `start_stop`.
  - Any state to IDLE on `clear`.
- Prescaler counts 0..`CLK_FREQ_HZ/TICK_HZ`-1. The internal tick is asserted in the cycle the prescaler equals the terminal count while in RUNNING; the prescaler then returns to 0.
- On tick, digit 0 increments. Digit k increments only when tick is asserted and all lower digits are at base-1. A digit at base-1 that increments goes to 0.
- When all digits are at max on tick: all digits go to 0, `wrap` pulses, and state stays RUNNING.
- Lap:
  - `lap` with `lap_active`=0 copies the live count into the lap register and sets `lap_active`.
  - `lap` with `lap_active`=1 clears `lap_active`.
  - `lap` is ignored in IDLE.
- `digits` shows the lap register when `lap_active`=1 and the live count otherwise. The live count keeps advancing while frozen.
- Priority for same-cycle inputs: `clear` > `start_stop` > `lap`. Inputs not taken are dropped, not queued.
- `clear` also resets `lap_active` and the lap register.

## Timing
- Reset values: state IDLE; `digits`=0, `running`=0, `lap_active`=0, `wrap`=0; prescaler 0; lap register 0.
- All outputs are registered.
- `running` changes in the cycle after the `start_stop` pulse.
- `digits` reflects an increment in the cycle after the tick cycle.
- `wrap` is asserted in the same cycle the zeroed `digits` first appear.
- First tick after IDLE to RUNNING occurs `CLK_FREQ_HZ/TICK_HZ` cycles after the `start_stop` pulse.
- Lap capture takes the live count from the same edge. If a tick coincides with `lap`, the pre-increment value is captured.
- `rst` asserted mid-count forces reset values at the next edge regardless of other inputs.
- `clear` in the cycle of a tick: count goes to 0 and no `wrap` is issued.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - Lap register, `lap` input handling and `lap_active` are present as described above.
- `STOPWATCH_LAP_EN` undefined:
  - `lap` is ignored and `lap_active` is tied to 0.
  - `digits` is always the live count.
  - No lap register is synthesised.

## Structure
- Package `stopwatch_pkg` holds:
  - the state enum (IDLE, RUNNING, PAUSED);
  - `DIGIT_W = 4`;
  - a function to extract the base of digit k from `DIGIT_BASES`.
- Sub-module `bcd_digit_counter`: parameter `BASE`; ports `clk`, `rst`, `clear`, `enable`, `value[3:0]`, `at_max`. One instance per digit via generate. Digit k's enable is the tick ANDed with `at_max` of all lower digits.

## Test plan
Use `CLK_FREQ_HZ`=10, `TICK_HZ`=1, `NUM_DIGITS`=2, `DIGIT_BASES`={6,10} unless noted.
- Reset then `start_stop` at cycle 0: `running`=1 at cycle 1; `digits`=8'h01 at cycle 11; `digits`=8'h10 after 10 ticks.
- Pause: run 3 ticks plus 4 cycles, `start_stop`, wait 50 cycles, `start_stop` again: `digits` stays 8'h03 throughout the pause; 8'h04 appears 6 cycles after resume.
- Run to 8'h59, then one more tick: `digits`=8'h00 with a single-cycle `wrap`=1; `running` stays 1.
- `STOPWATCH_LAP_EN` defined: `lap` at 8'h05, run 3 more ticks: `digits` holds 8'h05; second `lap` shows 8'h08.
- `clear`, `start_stop` and `lap` in the same cycle while RUNNING: next cycle state IDLE, `digits`=0, `running`=0, `lap_active`=0.
- `rst` pulsed mid-count at 8'h27: all outputs return to reset values; `start_stop` restarts the count from 8'h00.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and helpers for the stopwatch engine.
//   - sw_state_e : control state (idle / running / paused)
//   - DIGIT_W    : bits per displayed digit
//   - digit_base : extracts the base of digit k from a packed base vector
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StPaused  = 2'd2
  } sw_state_e;

  // Bases are packed DIGIT_W bits per digit, digit 0 in the LSBs (up to 8 digits).
  function automatic int unsigned digit_base(input logic [31:0] bases, input int unsigned k);
    return 32'(bases[k*DIGIT_W +: DIGIT_W]);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: single modulo-BASE digit of the stopwatch chain.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   clear  - synchronous zero of the digit
//   enable - advance by one this cycle (wraps BASE-1 -> 0)
//   value  - current digit value
//   at_max - digit currently equals BASE-1
module bcd_digit_counter #(
  parameter int unsigned BASE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] value,
  output logic       at_max
);

  localparam logic [3:0] MaxVal = 4'(BASE - 1);

  logic [3:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (enable) begin
      value_d = (value_q == MaxVal) ? 4'd0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign at_max = (value_q == MaxVal);

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: prescaled stopwatch with start/stop, clear and lap freeze.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start_stop        - pulse: idle/paused -> running, running -> paused
//   clear             - pulse: zero count, prescaler and lap, return to idle
//   lap               - pulse: toggle display freeze (ignored in idle)
//   digits            - displayed count, one digit per nibble, digit 0 in LSBs
//   running           - high while running
//   lap_active        - high while the display is frozen
//   wrap              - one-cycle pulse when the count rolls over to zero
// Build option: define STOPWATCH_LAP_EN to include the lap register and freeze logic;
// otherwise lap is ignored and lap_active is tied low.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned                  CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned                  TICK_HZ     = 100,
  parameter int unsigned                  NUM_DIGITS  = 4,
  parameter logic [4*NUM_DIGITS-1:0]      DIGIT_BASES = {4'd6, 4'd10, 4'd10, 4'd10}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    lap_active,
  output logic                    wrap
);

  localparam int unsigned SafeTick = (TICK_HZ == 0) ? 1 : TICK_HZ;
  localparam int unsigned Div      = CLK_FREQ_HZ / SafeTick;
  localparam int unsigned PreW     = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(Div - 1);

  if (TICK_HZ == 0 || (CLK_FREQ_HZ % SafeTick) != 0 || Div == 0) begin : g_bad_tick
    $error("CLK_FREQ_HZ must be a nonzero exact multiple of TICK_HZ");
  end
  if (NUM_DIGITS == 0 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be 1..8");
  end

  sw_state_e              state_q, state_d;
  logic [PreW-1:0]        pre_q, pre_d;
  logic                   wrap_q, wrap_d;
  logic                   tick;
  logic [NUM_DIGITS-1:0]  dig_at_max;
  logic [NUM_DIGITS-1:0]  dig_en;
  logic [4*NUM_DIGITS-1:0] live_count;

  assign tick = (state_q == StRunning) && (pre_q == PreMax);

  // Digit chain: digit k advances on a tick when every lower digit is at its maximum.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int unsigned Base = digit_base(32'(DIGIT_BASES), k);
    if (Base < 2 || Base > 10) begin : g_bad_base
      $error("each digit base must be 2..10");
    end
    if (k == 0) begin : g_lsd
      assign dig_en[k] = tick;
    end else begin : g_upper
      assign dig_en[k] = tick & (&dig_at_max[k-1:0]);
    end
    bcd_digit_counter #(
      .BASE (Base)
    ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .enable (dig_en[k]),
      .value  (live_count[k*DIGIT_W +: DIGIT_W]),
      .at_max (dig_at_max[k])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else if (start_stop) begin
      case (state_q)
        StIdle, StPaused: state_d = StRunning;
        StRunning:        state_d = StPaused;
        default:          state_d = StIdle;
      endcase
    end
  end

  // Prescaler only moves while running, so a pause keeps any partial tick.
  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (state_q == StRunning) begin
      pre_d = tick ? '0 : pre_q + PreW'(1);
    end
  end

  // Wrap coincides with the zeroed digits appearing; a same-cycle clear suppresses it.
  assign wrap_d = tick & (&dig_at_max) & ~clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pre_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      wrap_q  <= wrap_d;
    end
  end

  assign running = (state_q == StRunning);
  assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic                    lap_active_q, lap_active_d;
  logic [4*NUM_DIGITS-1:0] lap_q, lap_d;

  // start_stop outranks lap; a dropped lap is not retried.
  always_comb begin
    lap_active_d = lap_active_q;
    lap_d        = lap_q;
    if (clear) begin
      lap_active_d = 1'b0;
      lap_d        = '0;
    end else if (!start_stop && lap && state_q != StIdle) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else begin
        lap_active_d = 1'b1;
        lap_d        = live_count;  // pre-increment value if a tick coincides
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_active_q <= 1'b0;
      lap_q        <= '0;
    end else begin
      lap_active_q <= lap_active_d;
      lap_q        <= lap_d;
    end
  end

  assign lap_active = lap_active_q;
  assign digits     = lap_active_q ? lap_q : live_count;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign digits     = live_count;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed plus randomized checks of stopwatch_core against a
// count-level reference model (total elapsed ticks modulo 60 for bases {6,10}).
module tb_stopwatch_core;

  localparam int unsigned ClkHz  = 10;
  localparam int unsigned TickHz = 1;
  localparam int unsigned Nd     = 2;
  localparam logic [7:0]  Bases  = {4'd6, 4'd10};
  localparam int          Div    = ClkHz / TickHz;
  localparam int          Modulo = 60;
`ifdef STOPWATCH_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start_stop, clear, lap;
  logic [7:0] digits;
  logic       running, lap_active, wrap;

  always #5 clk = ~clk;

  stopwatch_core #(
    .CLK_FREQ_HZ (ClkHz),
    .TICK_HZ     (TickHz),
    .NUM_DIGITS  (Nd),
    .DIGIT_BASES (Bases)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .digits     (digits),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  typedef enum int {MIdle, MRun, MPause} mstate_e;

  mstate_e m_state;
  int      m_pre, m_count, m_lap_val;
  bit      m_lap_act, m_wrap;
  int      n_cmp = 0;
  int      n_err = 0;

  function automatic logic [7:0] as_digits(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit ss, input bit cl, input bit lp);
    int old;
    bit tk;
    old = m_count;
    if (r || cl) begin
      m_state = MIdle; m_pre = 0; m_count = 0; m_lap_val = 0; m_lap_act = 0; m_wrap = 0;
    end else begin
      tk     = (m_state == MRun) && (m_pre == Div - 1);
      m_wrap = 0;
      if (m_state == MRun) begin
        if (tk) begin
          m_pre   = 0;
          m_count = (m_count + 1) % Modulo;
          m_wrap  = (m_count == 0);
        end else begin
          m_pre++;
        end
      end
      if (ss) begin
        m_state = (m_state == MRun) ? MPause : MRun;
      end else if (lp && LapEn && m_state != MIdle) begin
        if (m_lap_act) m_lap_act = 0;
        else begin
          m_lap_act = 1;
          m_lap_val = old;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("digits", 32'(digits), 32'(as_digits(m_lap_act ? m_lap_val : m_count)));
    chk("running", 32'(running), 32'(m_state == MRun));
    chk("lap_active", 32'(lap_active), 32'(m_lap_act));
    chk("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic step(input bit r, input bit ss, input bit cl, input bit lp);
    rst = r; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    model_edge(r, ss, cl, lp);
    #1;
    rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 2000 && m_count != target; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    m_state = MIdle; m_pre = 0; m_count = 0; m_lap_val = 0; m_lap_act = 0; m_wrap = 0;

    // Reset values
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_running", 32'(running), 32'h0);

    // Start at cycle 0: running next cycle, first increment at cycle 11
    step(0, 1, 0, 0);
    chk("start_running", 32'(running), 32'h1);
    idle_steps(9);
    chk("before_first_tick", 32'(digits), 32'h00);
    step(0, 0, 0, 0);
    chk("first_tick", 32'(digits), 32'h01);
    idle_steps(90);
    chk("ten_ticks", 32'(digits), 32'h10);

    // Pause keeps partial tick; resume finishes it
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    idle_steps(34);
    chk("pre_pause", 32'(digits), 32'h03);
    step(0, 1, 0, 0);
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 0, 0);
      chk("paused_hold", 32'(digits), 32'h03);
    end
    step(0, 1, 0, 0);
    idle_steps(4);
    chk("resume_partial", 32'(digits), 32'h03);
    step(0, 0, 0, 0);
    chk("resume_tick", 32'(digits), 32'h04);

    // Rollover 59 -> 00 with a single wrap pulse
    run_until(59);
    chk("at_59", 32'(digits), 32'h59);
    for (int i = 0; i < 20 && m_count != 0; i++) step(0, 0, 0, 0);
    chk("wrap_digits", 32'(digits), 32'h00);
    chk("wrap_pulse", 32'(wrap), 32'h1);
    chk("wrap_running", 32'(running), 32'h1);
    step(0, 0, 0, 0);
    chk("wrap_single", 32'(wrap), 32'h0);

    // Lap freeze
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    run_until(5);
    step(0, 0, 0, 1);
`ifdef STOPWATCH_LAP_EN
    chk("lap_set", 32'(lap_active), 32'h1);
    idle_steps(30);
    chk("lap_frozen", 32'(digits), 32'h05);
    step(0, 0, 0, 1);
    chk("lap_release", 32'(digits), 32'h08);
    chk("lap_clear_flag", 32'(lap_active), 32'h0);
`else
    chk("lap_disabled_flag", 32'(lap_active), 32'h0);
    idle_steps(30);
    chk("lap_disabled_live", 32'(digits), 32'h08);
`endif

    // clear beats start_stop and lap in the same cycle
    step(0, 0, 0, 1);
    step(0, 1, 1, 1);
    chk("clr_prio_digits", 32'(digits), 32'h00);
    chk("clr_prio_running", 32'(running), 32'h0);
    chk("clr_prio_lap", 32'(lap_active), 32'h0);

    // rst mid-count at 27 overrides other inputs
    step(0, 1, 0, 0);
    run_until(27);
    chk("at_27", 32'(digits), 32'h27);
    step(1, 1, 0, 1);
    chk("rst_digits", 32'(digits), 32'h00);
    chk("rst_running", 32'(running), 32'h0);
    step(0, 1, 0, 0);
    chk("restart_running", 32'(running), 32'h1);
    idle_steps(10);
    chk("restart_first", 32'(digits), 32'h01);

    // Randomized control pulses checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 999) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 299) == 0,
           $urandom_range(0, 29) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
